// File: rtl/data_wbuf_pkg.sv
// Shared types and defaults for the data-side store write buffer.
package data_wbuf_pkg;

  localparam int unsigned DEPTH_DEF  = 4;
  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned PTR_W      = $clog2(DEPTH_DEF);

  // Buffered store at default widths: word address plus data.
  typedef struct packed {
    logic [ADDR_W_DEF-3:0] waddr;
    logic [DATA_W_DEF-1:0] data;
  } wbuf_entry_t;

  typedef enum logic [1:0] {
    PORT_IDLE,
    PORT_DRAIN,
    PORT_LOAD
  } port_op_e;

endpackage

// File: rtl/wbuf_fwd_match.sv
// Youngest-hit search over the live FIFO window [head, head+count).
module wbuf_fwd_match #(
  parameter  int unsigned DEPTH = 4,
  parameter  int unsigned KEY_W = 30,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]            valid,
  input  logic [DEPTH-1:0][KEY_W-1:0] keys,
  input  logic [KEY_W-1:0]            key,
  input  logic [PTR_W-1:0]            head,
  input  logic [PTR_W:0]              count,
  output logic                        hit,
  output logic [PTR_W-1:0]            idx
);

  logic [PTR_W-1:0] pos;

  // Walk oldest to youngest so the last hit found is the youngest.
  always_comb begin
    hit = 1'b0;
    idx = head;
    pos = head;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      pos = head + PTR_W'(i);
      if (((PTR_W+1)'(i) < count) && valid[pos] && (keys[pos] == key)) begin
        hit = 1'b1;
        idx = pos;
      end
    end
  end

endmodule

// File: rtl/data_wbuf.sv
// Store write buffer between memory stage and single-port data RAM:
// drains stores when the port is idle, loads take priority and forward.
module data_wbuf
  import data_wbuf_pkg::*;
#(
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memWriteM,
  input  logic              memReadM,
  input  logic [ADDR_W-1:0] data_ram_waddr,
  input  logic [DATA_W-1:0] data_ram_wdataM,
  output logic [DATA_W-1:0] data_ram_rdata,
  output logic              stall_wbuf,
  output logic              wbuf_empty,
  output logic              ram_req,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic              ram_gnt,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int unsigned PTR_BITS = $clog2(DEPTH);
  localparam int unsigned WA_W     = ADDR_W - 2;

  typedef struct packed {
    logic [WA_W-1:0]   waddr;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t [DEPTH-1:0]           ent;
  logic   [DEPTH-1:0]           vld;
  logic   [DEPTH-1:0][WA_W-1:0] ent_waddr;
  logic   [PTR_BITS-1:0]        head;
  logic   [PTR_BITS-1:0]        tail;
  logic   [PTR_BITS:0]          count;
  logic                         ld_pend;
  logic                         fwd_hit;
  logic   [DATA_W-1:0]          fwd_data;
  logic                         m_hit;
  logic   [PTR_BITS-1:0]        m_idx;
  logic                         enq;
  logic                         pop;
  port_op_e                     op;

  assign stall_wbuf = (count == (PTR_BITS+1)'(DEPTH));
  assign wbuf_empty = (count == '0);

  always_comb begin
    op = PORT_IDLE;
    if (memReadM)          op = PORT_LOAD;
    else if (count != '0)  op = PORT_DRAIN;
  end

  // A load in the same cycle as a store wins; the store is dropped.
  assign enq = memWriteM && !memReadM && !stall_wbuf;
  assign pop = (op == PORT_DRAIN) && ram_gnt;

  always_comb begin
    ram_req   = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = {ent[head].waddr, 2'b00};
    ram_wdata = ent[head].data;
    case (op)
      PORT_LOAD: begin
        ram_req  = 1'b1;
        ram_addr = data_ram_waddr;
      end
      PORT_DRAIN: begin
        ram_req = 1'b1;
        ram_we  = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      ent_waddr[i] = ent[i].waddr;
    end
  end

  wbuf_fwd_match #(
    .DEPTH (DEPTH),
    .KEY_W (WA_W)
  ) u_fwd_match (
    .valid (vld),
    .keys  (ent_waddr),
    .key   (data_ram_waddr[ADDR_W-1:2]),
    .head  (head),
    .count (count),
    .hit   (m_hit),
    .idx   (m_idx)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ent      <= '0;
      vld      <= '0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      ld_pend  <= 1'b0;
      fwd_hit  <= 1'b0;
      fwd_data <= '0;
    end else begin
      // enq and pop never target the same slot: that needs full or empty.
      if (enq) begin
        ent[tail] <= '{waddr: data_ram_waddr[ADDR_W-1:2], data: data_ram_wdataM};
        vld[tail] <= 1'b1;
        tail      <= tail + 1'b1;
      end
      if (pop) begin
        vld[head] <= 1'b0;
        head      <= head + 1'b1;
      end
      case ({enq, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      ld_pend <= memReadM;
      if (memReadM) begin
        fwd_hit  <= m_hit;
        fwd_data <= ent[m_idx].data;
      end
    end
  end

  assign data_ram_rdata = ld_pend ? (fwd_hit ? fwd_data : ram_rdata) : '0;

endmodule

// File: tb/tb_data_wbuf.sv
// Scoreboard bench for data_wbuf: expected RAM writes and load results are
// queued by the stimulus and checked by an independent monitor.
module tb_data_wbuf;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          memWriteM = 1'b0;
  logic          memReadM = 1'b0;
  logic [AW-1:0] data_ram_waddr = '0;
  logic [DW-1:0] data_ram_wdataM = '0;
  logic [DW-1:0] data_ram_rdata;
  logic          stall_wbuf;
  logic          wbuf_empty;
  logic          ram_req;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          ram_gnt = 1'b0;
  logic [DW-1:0] ram_rdata;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t           wq[$];
  logic [DW-1:0] lq[$];
  logic          ld_seen;

  always #5 clk = ~clk;

  data_wbuf #(
    .DEPTH  (4),
    .ADDR_W (AW),
    .DATA_W (DW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .memWriteM       (memWriteM),
    .memReadM        (memReadM),
    .data_ram_waddr  (data_ram_waddr),
    .data_ram_wdataM (data_ram_wdataM),
    .data_ram_rdata  (data_ram_rdata),
    .stall_wbuf      (stall_wbuf),
    .wbuf_empty      (wbuf_empty),
    .ram_req         (ram_req),
    .ram_we          (ram_we),
    .ram_addr        (ram_addr),
    .ram_wdata       (ram_wdata),
    .ram_gnt         (ram_gnt),
    .ram_rdata       (ram_rdata)
  );

  function automatic logic [DW-1:0] ram_val(input logic [AW-1:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // RAM read model: data one cycle after the read request.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      ram_rdata <= '0;
      ld_seen   <= 1'b0;
    end else begin
      ld_seen <= memReadM;
      if (ram_req && !ram_we) ram_rdata <= ram_val(ram_addr);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic flag_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // Monitor: compare every accepted RAM write and every load result.
  always @(negedge clk) begin
    if (rst) begin
      if (ram_req && ram_we && ram_gnt) begin
        if (wq.size() == 0) flag_fail("unexpected_ram_write");
        else begin
          wr_t e;
          e = wq.pop_front();
          chk("drain_addr", ram_addr, e.a);
          chk("drain_data", ram_wdata, e.d);
        end
      end
      if (ld_seen) begin
        if (lq.size() == 0) flag_fail("unexpected_load_result");
        else chk("load_data", data_ram_rdata, lq.pop_front());
      end else begin
        chk("rdata_idle_zero", data_ram_rdata, '0);
      end
      if (memWriteM && stall_wbuf) flag_fail("store_while_full");
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_t e;
    memWriteM       = 1'b1;
    data_ram_waddr  = a;
    data_ram_wdataM = d;
    e.a = {a[AW-1:2], 2'b00};
    e.d = d;
    wq.push_back(e);
    tick();
    memWriteM = 1'b0;
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] exp);
    memReadM       = 1'b1;
    data_ram_waddr = a;
    lq.push_back(exp);
    @(negedge clk);
    chk("load_req", ram_req, 1'b1);
    chk("load_we", ram_we, 1'b0);
    chk("load_addr", ram_addr, a);
    tick();
    memReadM = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned w;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", stall_wbuf, 1'b0);
    chk("rst_empty", wbuf_empty, 1'b1);
    chk("rst_req", ram_req, 1'b0);
    chk("rst_we", ram_we, 1'b0);
    chk("rst_rdata", data_ram_rdata, '0);
    tick();
    rst = 1'b1;
    tick();

    // Reset while stores are pending: they are discarded
    ram_gnt = 1'b0;
    store(32'h40, 32'h0000_AAAA);
    store(32'h44, 32'h0000_BBBB);
    store(32'h48, 32'h0000_CCCC);
    @(negedge clk);
    chk("middrain_req", ram_req, 1'b1);
    tick();
    rst = 1'b0;
    #1;
    chk("midrst_empty", wbuf_empty, 1'b1);
    chk("midrst_stall", stall_wbuf, 1'b0);
    chk("midrst_req", ram_req, 1'b0);
    chk("midrst_rdata", data_ram_rdata, '0);
    wq.delete();
    lq.delete();
    tick();
    rst = 1'b1;
    ram_gnt = 1'b1;
    repeat (4) tick();
    @(negedge clk);
    chk("postrst_req", ram_req, 1'b0);
    tick();

    // Single store, drained the next cycle
    store(32'h10, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("single_req", ram_req, 1'b1);
    chk("single_we", ram_we, 1'b1);
    chk("single_addr", ram_addr, 32'h10);
    chk("single_wdata", ram_wdata, 32'hDEAD_BEEF);
    tick();
    @(negedge clk);
    chk("single_empty", wbuf_empty, 1'b1);
    tick();

    // Fill to full with no grant; pointers wrap from head=1
    ram_gnt = 1'b0;
    store(32'h0, 32'h1000);
    store(32'h4, 32'h1004);
    store(32'h8, 32'h1008);
    store(32'hC, 32'h100C);
    @(negedge clk);
    chk("full_stall", stall_wbuf, 1'b1);
    chk("full_head_addr", ram_addr, 32'h0);
    tick();
    ram_gnt = 1'b1;
    tick();
    ram_gnt = 1'b0;
    @(negedge clk);
    chk("after_pop_stall", stall_wbuf, 1'b0);
    chk("after_pop_addr", ram_addr, 32'h4);
    tick();
    ram_gnt = 1'b1;
    repeat (5) tick();
    @(negedge clk);
    chk("fill_drained", wbuf_empty, 1'b1);
    tick();

    // Forwarding: youngest match wins, miss passes RAM data through
    ram_gnt = 1'b0;
    store(32'h20, 32'h11);
    store(32'h20, 32'h22);
    load(32'h20, 32'h22);
    load(32'h24, ram_val(32'h24));
    load(32'h23, 32'h22);
    tick();
    ram_gnt = 1'b1;
    repeat (4) tick();
    @(negedge clk);
    chk("fwd_drained", wbuf_empty, 1'b1);
    tick();

    // Loads hold off draining even with grant
    ram_gnt = 1'b0;
    store(32'h30, 32'h33);
    store(32'h34, 32'h44);
    ram_gnt = 1'b1;
    load(32'h100, ram_val(32'h100));
    load(32'h104, ram_val(32'h104));
    load(32'h108, ram_val(32'h108));
    @(negedge clk);
    chk("resume_we", ram_we, 1'b1);
    chk("resume_addr", ram_addr, 32'h30);
    tick();
    repeat (3) tick();
    @(negedge clk);
    chk("prio_drained", wbuf_empty, 1'b1);
    tick();

    // Enqueue and pop together at count=2, then random-grant stream
    ram_gnt = 1'b0;
    store(32'h50, 32'h5001);
    store(32'h54, 32'h5002);
    ram_gnt = 1'b1;
    store(32'h58, 32'h5003);
    @(negedge clk);
    chk("encpop_empty", wbuf_empty, 1'b0);
    chk("encpop_stall", stall_wbuf, 1'b0);
    chk("encpop_head", ram_addr, 32'h54);
    tick();
    for (int i = 0; i < 8; i++) begin
      ram_gnt = 1'($urandom_range(0, 1));
      w = 0;
      while (stall_wbuf && w < 20) begin
        ram_gnt = 1'b1;
        tick();
        w++;
      end
      chk("stall_release", stall_wbuf, 1'b0);
      store(32'h60 + 32'(4 * i), 32'hA000 + 32'(i));
    end
    ram_gnt = 1'b1;
    repeat (8) tick();
    @(negedge clk);
    chk("final_empty", wbuf_empty, 1'b1);
    chk("writes_outstanding", 64'(wq.size()), 0);
    chk("loads_outstanding", 64'(lq.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
